// File: rtl/wb_arbiter_if.sv
// Bundle of write-back arbiter signals: ALU and long-latency result inputs, register-file write port, hazard query.
// Handshake: a mem result transfers on a rising edge where mem_valid && mem_ready; an ALU result is taken on any edge where alu_valid && !alu_stall, otherwise upstream holds alu_* stable.
interface wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int DEPTH      = 4
);
    logic                         alu_valid;
    logic [ADR_WIDTH-1:0]         alu_rd;
    logic [DATA_WIDTH-1:0]        alu_data;
    logic                         alu_stall;
    logic                         mem_valid;
    logic                         mem_ready;
    logic [ADR_WIDTH-1:0]         mem_rd;
    logic [DATA_WIDTH-1:0]        mem_data;
    logic                         we3;
    logic [ADR_WIDTH-1:0]         wa3;
    logic [DATA_WIDTH-1:0]        wd3;
    logic [ADR_WIDTH-1:0]         rs1;
    logic [ADR_WIDTH-1:0]         rs2;
    logic                         rs1_pending;
    logic                         rs2_pending;
    logic [$clog2(DEPTH):0]       count;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
        output alu_stall, mem_ready, we3, wa3, wd3, rs1_pending, rs2_pending, count
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
        input  alu_stall, mem_ready, we3, wa3, wd3, rs1_pending, rs2_pending, count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results with a FIFO of long-latency results
// into one registered register-file write port, and flags source registers with writes in flight.
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 5,
    parameter int DEPTH      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADR_WIDTH-1:0]  rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  full, empty, mem_fire, push, pop, sel_valid;
    logic [ADR_WIDTH-1:0]  sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  we3_r;
    logic [ADR_WIDTH-1:0]  wa3_r;
    logic [DATA_WIDTH-1:0] wd3_r;

    logic [DEPTH-1:0]      occupied;
    logic [PTR_W-1:0]      offset;
    logic                  hit1, hit2;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign mem_fire = bus.mem_valid && !full;

    assign bus.mem_ready = !full;
    assign bus.alu_stall = bus.alu_valid && full;
    assign bus.count     = count;
    assign bus.we3       = we3_r;
    assign bus.wa3       = wa3_r;
    assign bus.wd3       = wd3_r;

    // A full queue outranks the ALU so the long-latency pipe can never deadlock.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        pop       = 1'b0;
        push      = mem_fire;
        if (full) begin
            sel_valid = 1'b1;
            sel_rd    = rd_q[rd_ptr];
            sel_data  = data_q[rd_ptr];
            pop       = 1'b1;
        end else if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end else if (!empty) begin
            sel_valid = 1'b1;
            sel_rd    = rd_q[rd_ptr];
            sel_data  = data_q[rd_ptr];
            pop       = 1'b1;
        end else if (mem_fire) begin
            sel_valid = 1'b1;
            sel_rd    = bus.mem_rd;
            sel_data  = bus.mem_data;
            push      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr]   <= bus.mem_rd;
            data_q[wr_ptr] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Register x0 is consumed like any other entry but never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_r <= 1'b0;
            wa3_r <= '0;
            wd3_r <= '0;
        end else if (sel_valid) begin
            we3_r <= (sel_rd != '0);
            wa3_r <= sel_rd;
            wd3_r <= sel_data;
        end else begin
            we3_r <= 1'b0;
        end
    end

    always_comb begin
        occupied = '0;
        offset   = '0;
        hit1     = we3_r && (wa3_r == bus.rs1);
        hit2     = we3_r && (wa3_r == bus.rs2);
        for (int j = 0; j < DEPTH; j++) begin
            offset      = PTR_W'(j) - rd_ptr;
            occupied[j] = ({1'b0, offset} < count);
            if (occupied[j] && rd_q[j] == bus.rs1) hit1 = 1'b1;
            if (occupied[j] && rd_q[j] == bus.rs2) hit2 = 1'b1;
        end
    end

    assign bus.rs1_pending = (bus.rs1 != '0) && hit1;
    assign bus.rs2_pending = (bus.rs2 != '0) && hit2;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, bypass, full-queue priority, hazard flags, x0 and async reset.
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [AW-1:0] exp_q[$];

  wb_arbiter_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DP)) bus ();

  wb_arbiter #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
  endtask

  task automatic drive_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    bus.mem_valid = v;
    bus.mem_rd    = rd;
    bus.mem_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] rd);
    return (rd >= 5'd20) ? (32'hA00 + 32'(rd)) : (32'h100 + 32'(rd));
  endfunction

  initial begin
    int ai;
    int mi;
    int writes;
    logic [AW-1:0] e;
    n_checks = 0;
    n_errors = 0;
    drive_idle();
    rst_n = 1'b0;

    // reset state
    #12;
    bus.alu_valid = 1'b1;
    #1;
    check("rst_we3", bus.we3, 0);
    check("rst_wa3", bus.wa3, 0);
    check("rst_wd3", bus.wd3, 0);
    check("rst_count", bus.count, 0);
    check("rst_mem_ready", bus.mem_ready, 1);
    check("rst_alu_stall", bus.alu_stall, 0);
    check("rst_rs1_pending", bus.rs1_pending, 0);
    drive_idle();
    tick();
    rst_n = 1'b1;

    // single ALU write, then idle
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    check("alu_we3", bus.we3, 1);
    check("alu_wa3", bus.wa3, 5);
    check("alu_wd3", bus.wd3, 32'hDEADBEEF);
    drive_alu(1'b0, '0, '0);
    tick();
    check("alu_idle_we3", bus.we3, 0);
    check("alu_idle_wa3_hold", bus.wa3, 5);
    check("alu_idle_wd3_hold", bus.wd3, 32'hDEADBEEF);

    // mem bypass with empty queue
    drive_mem(1'b1, 5'd7, 32'h11);
    #1;
    check("byp_mem_ready", bus.mem_ready, 1);
    tick();
    check("byp_we3", bus.we3, 1);
    check("byp_wa3", bus.wa3, 7);
    check("byp_wd3", bus.wd3, 32'h11);
    check("byp_count", bus.count, 0);
    drive_mem(1'b0, '0, '0);
    tick();

    // six ALU results competing with six mem results; hand-derived commit order
    exp_q = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd1, 5'd24, 5'd2, 5'd25, 5'd3, 5'd4, 5'd5, 5'd6};
    ai = 0;
    mi = 0;
    writes = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      drive_alu(ai < 6, 5'(20 + ai), model_data(5'(20 + ai)));
      drive_mem(mi < 6, 5'(1 + mi), model_data(5'(1 + mi)));
      #1;
      if (cyc == 4) begin
        check("full_count", bus.count, 4);
        check("full_mem_ready", bus.mem_ready, 0);
        check("full_alu_stall", bus.alu_stall, 1);
      end
      if (bus.alu_valid && !bus.alu_stall) ai++;
      if (bus.mem_valid && bus.mem_ready) mi++;
      @(posedge clk);
      #1;
      if (bus.we3) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("prio_extra_write", bus.wa3, 0);
        end else begin
          e = exp_q.pop_front();
          check("prio_wa3", bus.wa3, e);
          check("prio_wd3", bus.wd3, model_data(e));
        end
      end
    end
    check("prio_writes", writes, 12);
    check("prio_left", exp_q.size(), 0);
    check("prio_count_end", bus.count, 0);
    drive_idle();
    tick();

    // hazard flags with rd=9 queued behind an ALU write
    drive_alu(1'b1, 5'd10, 32'h10);
    drive_mem(1'b1, 5'd9, 32'h99);
    tick();
    drive_idle();
    bus.rs1 = 5'd9;
    bus.rs2 = 5'd0;
    #1;
    check("haz_count", bus.count, 1);
    check("haz_rs1_pending_q", bus.rs1_pending, 1);
    check("haz_rs2_pending", bus.rs2_pending, 0);
    tick();
    check("haz_commit_wa3", bus.wa3, 9);
    check("haz_rs1_pending_out", bus.rs1_pending, 1);
    tick();
    check("haz_rs1_cleared", bus.rs1_pending, 0);

    // x0 destination is consumed without a write
    drive_alu(1'b1, 5'd0, 32'h1234);
    tick();
    check("x0_we3", bus.we3, 0);
    drive_idle();
    tick();

    // fill three entries, then assert reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      drive_alu(1'b1, 5'd30, 32'h30);
      drive_mem(1'b1, 5'(11 + k), 32'h200);
      tick();
    end
    check("fill_count", bus.count, 3);
    drive_idle();
    bus.rs1 = 5'd11;
    #1;
    check("fill_rs1_pending", bus.rs1_pending, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_we3", bus.we3, 0);
    check("arst_count", bus.count, 0);
    check("arst_mem_ready", bus.mem_ready, 1);
    check("arst_rs1_pending", bus.rs1_pending, 0);
    tick();
    rst_n = 1'b1;
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.we3) writes++;
    end
    check("post_rst_writes", writes, 0);
    check("post_rst_count", bus.count, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
